// File: rtl/gate_count_latch_pkg.sv
// Shared types and constants for the gate/count/latch stage of the frequency meter.
package gate_count_latch_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    COUNT    = 2'd2,
    LATCH    = 2'd3
  } gcl_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  localparam logic MODE_FREQ   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

endpackage

// File: rtl/gate_count_latch_bcd_digit_cnt.sv
// One BCD digit of the window counter; digits are chained through carry_in/carry_out.
module bcd_digit_cnt
  import gate_count_latch_pkg::*;
(
  input  logic       CP,
  input  logic       clr,
  input  logic       inc,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       at_max
);

  assign at_max    = (q == BCD_MAX_DIGIT);
  // A clearing cycle must not ripple old 9s upward, so the chain is cut here.
  assign carry_out = carry_in & at_max & ~clr;

  always_ff @(posedge CP) begin
    if (clr)
      q <= {3'b000, inc & carry_in};
    else if (inc & carry_in)
      q <= at_max ? 4'd0 : q + 4'd1;
  end

endmodule

// File: rtl/gate_count_latch.sv
// Gate/count/latch: BCD-counts source edges while the synchronised gate is high and latches on gate fall.
// Optional auto-range request pulses are built only with GATE_COUNT_AUTO_RANGE_EN defined.
module gate_count_latch
  import gate_count_latch_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
)(
  input  logic                  CP,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic                  CPx,
  input  logic                  Ref_CP,
  input  logic                  measure_mode,
  input  logic                  range_change,
  output logic [4*DIGITS-1:0]   Count_Data,
  output logic                  Data_Valid,
  output logic                  Overflow,
  output logic                  Busy,
  output logic                  range_up,
  output logic                  range_down
);

  // Synchronisers keep shifting through reset so they hold real input levels on release.
  logic [SYNC_STAGES-1:0] en_sync, cpx_sync, ref_sync, mm_sync, rc_sync;
  logic                   en_d, cpx_d, ref_d, mm_d;

  always_ff @(posedge CP) begin
    en_sync  <= {en_sync[SYNC_STAGES-2:0],  Enable};
    cpx_sync <= {cpx_sync[SYNC_STAGES-2:0], CPx};
    ref_sync <= {ref_sync[SYNC_STAGES-2:0], Ref_CP};
    mm_sync  <= {mm_sync[SYNC_STAGES-2:0],  measure_mode};
    rc_sync  <= {rc_sync[SYNC_STAGES-2:0],  range_change};
    en_d     <= en_sync[SYNC_STAGES-1];
    cpx_d    <= cpx_sync[SYNC_STAGES-1];
    ref_d    <= ref_sync[SYNC_STAGES-1];
    mm_d     <= mm_sync[SYNC_STAGES-1];
  end

  logic en_s, mm_s, rc_s, src_s, src_d;
  logic gate_rise, gate_fall, src_rise, abort;

  assign en_s      = en_sync[SYNC_STAGES-1];
  assign mm_s      = mm_sync[SYNC_STAGES-1];
  assign rc_s      = rc_sync[SYNC_STAGES-1];
  assign src_s     = (mm_s == MODE_FREQ) ? cpx_sync[SYNC_STAGES-1] : ref_sync[SYNC_STAGES-1];
  assign src_d     = (mm_s == MODE_FREQ) ? cpx_d : ref_d;
  assign src_rise  = src_s & ~src_d;
  assign gate_rise = en_s & ~en_d;
  assign gate_fall = ~en_s & en_d;
  assign abort     = (mm_s != mm_d) | ~rc_s;

  gcl_state_e state, state_nx;

  always_ff @(posedge CP) begin
    if (Rst) state <= WAIT_LOW;
    else     state <= state_nx;
  end

  // Abort wins over every transition, including a gate fall in the same cycle.
  always_comb begin
    state_nx = state;
    if (abort)
      state_nx = WAIT_LOW;
    else begin
      unique case (state)
        WAIT_LOW: if (!en_s)     state_nx = ARMED;
        ARMED:    if (gate_rise) state_nx = COUNT;
        COUNT:    if (gate_fall) state_nx = LATCH;
        LATCH:                   state_nx = ARMED;
        default:                 state_nx = WAIT_LOW;
      endcase
    end
  end

  logic win_start, cnt_edge, latch_go;

  always_comb begin
    Busy      = (state == COUNT);
    win_start = (state == ARMED) & gate_rise & ~abort & ~Rst;
    cnt_edge  = src_rise & ~abort & ~Rst & (win_start | (state == COUNT));
    latch_go  = (state == LATCH) & ~abort;
  end

  logic [DIGITS-1:0][3:0] cnt;
  logic [DIGITS:0]        carry;
  logic [DIGITS-1:0]      at_max;
  logic                   clr, inc, sat, ovf;

  assign carry[0] = 1'b1;
  assign sat      = &at_max;
  assign clr      = Rst | abort | win_start;
  // A start edge loads 1 even if the stale counter sits at all-9s.
  assign inc      = cnt_edge & (win_start | ~sat);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cnt u_digit (
      .CP        (CP),
      .clr       (clr),
      .inc       (inc),
      .carry_in  (carry[g]),
      .q         (cnt[g]),
      .carry_out (carry[g+1]),
      .at_max    (at_max[g])
    );
  end

  always_ff @(posedge CP) begin
    if (clr)                          ovf <= 1'b0;
    else if (cnt_edge & carry[DIGITS]) ovf <= 1'b1;
  end

  always_ff @(posedge CP) begin
    if (Rst) begin
      Count_Data <= '0;
      Overflow   <= 1'b0;
      Data_Valid <= 1'b0;
    end else begin
      Data_Valid <= latch_go;
      if (latch_go) begin
        Count_Data <= cnt;
        Overflow   <= ovf;
      end
    end
  end

`ifdef GATE_COUNT_AUTO_RANGE_EN
  always_ff @(posedge CP) begin
    if (Rst) begin
      range_up   <= 1'b0;
      range_down <= 1'b0;
    end else begin
      range_up   <= latch_go & ovf;
      range_down <= latch_go & ~ovf & (cnt[DIGITS-1] == 4'd0);
    end
  end
`else
  assign range_up   = 1'b0;
  assign range_down = 1'b0;
`endif

endmodule

// File: tb/tb_gate_count_latch.sv
// Directed bench for gate_count_latch: raw-sample window model feeds a scoreboard checked on Data_Valid.
module tb_gate_count_latch;

  localparam int DIGITS      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int W           = 4 * DIGITS;
  localparam int MAXV        = 10**DIGITS - 1;

  logic         CP = 1'b0;
  logic         Rst = 1'b1, Enable = 1'b0, CPx = 1'b0, Ref_CP = 1'b0;
  logic         measure_mode = 1'b0, range_change = 1'b1;
  logic [W-1:0] Count_Data;
  logic         Data_Valid, Overflow, Busy, range_up, range_down;

  gate_count_latch #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CP           (CP),
    .Rst          (Rst),
    .Enable       (Enable),
    .CPx          (CPx),
    .Ref_CP       (Ref_CP),
    .measure_mode (measure_mode),
    .range_change (range_change),
    .Count_Data   (Count_Data),
    .Data_Valid   (Data_Valid),
    .Overflow     (Overflow),
    .Busy         (Busy),
    .range_up     (range_up),
    .range_down   (range_down)
  );

  initial forever #5 CP = ~CP;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    logic         up;
    logic         dn;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0, errors = 0, cyc_n = 0;
  bit           rst_v = 1'b1, mm_v = 1'b0, rc_v = 1'b1, win_ok = 1'b0, mon_en = 1'b0;
  bit           en_prev = 1'b0, s_prev = 1'b0, alt = 1'b0, m_ovf = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] last_data = '0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CP cycle: drive inputs after the edge, then advance the raw-sample window model.
  task automatic step(input bit en, input bit s);
    exp_t e;
    @(posedge CP);
    cyc_n++;
    #1;
    alt          = ~alt;
    Rst          = rst_v;
    Enable       = en;
    measure_mode = mm_v;
    range_change = rc_v;
    if (mm_v) begin Ref_CP = s;  CPx    = alt; end
    else      begin CPx    = s;  Ref_CP = alt; end
    if (en & ~en_prev) begin m_cnt = 0; m_ovf = 1'b0; end
    if (s & ~s_prev & (en | en_prev)) begin
      if (m_cnt == MAXV) m_ovf = 1'b1;
      else               m_cnt++;
    end
    if (~en & en_prev & win_ok) begin
      e.data = to_bcd(m_cnt);
      e.ovf  = m_ovf;
`ifdef GATE_COUNT_AUTO_RANGE_EN
      e.up   = m_ovf;
      e.dn   = ~m_ovf & (m_cnt < 10**(DIGITS-1));
`else
      e.up   = 1'b0;
      e.dn   = 1'b0;
`endif
      e.due  = cyc_n + SYNC_STAGES + 2;
      sb.push_back(e);
    end
    en_prev = en;
    s_prev  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic window(input int len, input int per, input int ph, input bit chk_busy);
    for (int i = 0; i < len; i++) begin
      step(1'b1, ((i + ph) % per) >= (per / 2));
      if (chk_busy && i == len / 2) chk("busy_in_window", Busy, 1);
    end
    step(1'b0, ((len + ph) % per) >= (per / 2));
    idle(10);
    chk("busy_after_window", Busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, Count_Data, 0);
    chk({tag, "_valid"}, Data_Valid, 0);
    chk({tag, "_ovf"},   Overflow,   0);
    chk({tag, "_busy"},  Busy,       0);
    chk({tag, "_up"},    range_up,   0);
    chk({tag, "_dn"},    range_down, 0);
  endtask

  always @(negedge CP) begin
    if (mon_en) begin
      if (Data_Valid) begin
        chk("dv_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("count_data", Count_Data, mon_e.data);
          chk("overflow",   Overflow,   mon_e.ovf);
          chk("range_up",   range_up,   mon_e.up);
          chk("range_down", range_down, mon_e.dn);
          chk("dv_latency", cyc_n,      mon_e.due);
          last_data = mon_e.data;
        end
      end else begin
        chk("data_stable", Count_Data, last_data);
        chk("range_quiet", {range_up, range_down}, 0);
      end
    end
  end

  initial begin
    // Reset held for three edges with the gate low.
    repeat (3) step(1'b0, 1'b0);
    chk_reset_outputs("reset_held");
    rst_v = 1'b0;
    idle(8);
    chk_reset_outputs("reset_release");
    mon_en = 1'b1;

    // Frequency mode, 100-CP gate, CPx period 8.
    win_ok = 1'b1;
    window(100, 8, 0, 1'b1);

    // Source edge coincident with gate rise, then with gate fall.
    window(3, 100, 50, 1'b0);
    window(10, 4, 0, 1'b0);

    // range_change pulsed low for 5 CP mid-window: window discarded.
    win_ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rc_v = !(i >= 10 && i < 15);
      step(1'b1, (i % 6) >= 3);
    end
    rc_v = 1'b1;
    step(1'b0, 1'b0);
    idle(10);
    chk("abort_rc_hold", Count_Data, last_data);
    win_ok = 1'b1;
    window(40, 8, 3, 1'b1);

    // measure_mode toggled mid-window: window discarded.
    win_ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) mm_v = 1'b1;
      step(1'b1, (i % 6) >= 3);
    end
    step(1'b0, 1'b0);
    idle(10);
    chk("abort_mode_hold", Count_Data, last_data);
    win_ok = 1'b1;
    window(40, 8, 3, 1'b0);

    // Period mode saturation: Ref_CP period 4 over a 40100-CP gate.
    window(40100, 4, 0, 1'b1);

    // Back to frequency mode (mode change while idle aborts nothing visible); count 50.
    mm_v = 1'b0;
    idle(10);
    window(100, 2, 0, 1'b0);

    // Gate already high at reset release: that window must not report.
    mon_en = 1'b0;
    win_ok = 1'b0;
    rst_v  = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    chk_reset_outputs("reset_gate_high");
    rst_v     = 1'b0;
    last_data = '0;
    mon_en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 4) >= 2);
      if (i == 7) chk("busy_wait_low", Busy, 0);
    end
    step(1'b0, 1'b0);
    idle(10);
    win_ok = 1'b1;
    window(40, 8, 1, 1'b1);

    idle(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_count_latch.md
Name: gate_count_latch

Overview:
- Downstream consumer of the measurement gate produced by the Enable mux/toggle stage of the frequency meter.
- Synchronises the asynchronous gate and count sources into the CP domain.
- Counts rising edges of the selected source in BCD while the gate is high, then latches the result on gate fall.
- Feeds the display/decoder stage with a stable result, a valid strobe and an overflow flag.

Parameters:
DIGITS, 4, number of BCD digits in the counter and result (result width 4*DIGITS).
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).

Ports:
CP  input  1  system clock; must exceed 2x the fastest count source.
Rst  input  1  synchronous, active-high reset.
Enable  input  1  asynchronous measurement gate from the upstream toggle stage.
CPx  input  1  asynchronous unknown input signal.
Ref_CP  input  1  asynchronous reference time-base.
measure_mode  input  1  0 = frequency mode (count CPx); 1 = period mode (count Ref_CP).
range_change  input  1  active-low range-switch strobe, asynchronous.
Count_Data  output  4*DIGITS  latched BCD result; digit 0 in bits [3:0].
Data_Valid  output  1  one-CP pulse when Count_Data updates.
Overflow  output  1  latched with Count_Data; count exceeded all-9s.
Busy  output  1  high while in COUNT.
range_up  output  1  one-CP pulse request for a coarser range (AUTO_RANGE_EN only).
range_down  output  1  one-CP pulse request for a finer range (AUTO_RANGE_EN only).

Behaviour:
Synchronisation and sampling:
- Enable, CPx, Ref_CP and range_change each pass through a SYNC_STAGES synchroniser.
- The CPx/Ref_CP source is selected by the synchronised measure_mode.
- Rising edges of the selected source and rising/falling edges of the gate are detected by comparing the synchroniser output with one extra registered copy.

Reset:
- Rst=1 at a CP edge: Count_Data=0, Data_Valid=0, Overflow=0, Busy=0, range_up=0, range_down=0.
- Counter cleared; state = WAIT_LOW.

FSM:
- WAIT_LOW: wait until the synchronised gate is low, then go to ARMED. This prevents partial first windows after reset or an abort.
- ARMED: on gate rise, go to COUNT, clear the counter and set Busy. A source edge in the same cycle loads 1, not 0.
- COUNT: each source edge adds 1 in BCD with digit carry. On gate fall, go to LATCH; a source edge in the same cycle is included before the latch.
- LATCH: for one cycle, Count_Data <= counter, Overflow <= ovf, Data_Valid=1, Busy=0. Then go to ARMED.

Arithmetic and overflow:
- At all-9s, a further edge sets sticky ovf, and the counter holds all-9s (saturates).
- ovf is cleared at each window start.

Latency:
- Data_Valid asserts 1 cycle after the synchronised gate fall is detected.
- That is SYNC_STAGES+2 CP edges after the raw Enable fall.

Aborts:
- A change of synchronised measure_mode, or synchronised range_change=0, in any state moves to WAIT_LOW and clears the counter.
- No Data_Valid is produced; Count_Data and Overflow keep their previous values.
- The abort takes priority over a simultaneous gate fall.

Other rules:
- Count_Data is stable between Data_Valid pulses.
- Rst mid-COUNT discards the window.

Optional Feature:
GATE_COUNT_AUTO_RANGE_EN
- Defined: in the LATCH cycle, range_up=1 if ovf. Otherwise range_down=1 if the most-significant digit is 0. Both are single-cycle pulses, coincident with Data_Valid, and mutually exclusive.
- Undefined: the range_up and range_down ports remain present and are tied to 0; no compare logic is built.

Decomposition:
- Shared package holds:
  - state enum (WAIT_LOW, ARMED, COUNT, LATCH);
  - constant BCD_MAX_DIGIT=4'd9;
  - mode constants MODE_FREQ=0 and MODE_PERIOD=1.
- Sub-module bcd_digit_cnt: one 4-bit BCD digit with clr, inc, carry_in, carry_out and at_max. It is instantiated DIGITS times in a generate chain.
- Synchronisers are inline.

Test Plan:
- Rst held 3 cycles -> all outputs 0 and state WAIT_LOW. Then Enable high for 100 CP, mode 0, CPx period 8 CP, Enable falls -> Data_Valid pulse once, Count_Data=16'h0012 or 16'h0013 depending on phase, Overflow=0.
- Enable already high at reset release, then falls -> no Data_Valid. The next full window counts normally.
- Mode 1, Ref_CP period 4 CP, gate 40100 CP, DIGITS=4 -> Count_Data=16'h9999, Overflow=1. With the macro defined, range_up=1 in the same cycle as Data_Valid.
- range_change pulsed low for 5 CP mid-window -> no Data_Valid and Count_Data unchanged. The following window is correct.
- measure_mode toggled mid-window -> abort with no Data_Valid. Gate edge coincident with a source edge -> the edge is counted at both window start and end (check totals of 1 and N).
- Macro defined, count 0x0050 -> range_down=1. Macro undefined -> range_up and range_down are 0 throughout all tests.
